// File: rtl/procz_pkg.sv
// Shared processor Z definitions: run-state encoding, halt icode and
// instruction RAM geometry used by imem_run_ctrl, ram and regfile.
package procz_pkg;

  localparam int PROCZ_ADDR_W = 9;
  localparam int PROCZ_DATA_W = 32;

  localparam logic [3:0] ICODE_HALT = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } run_state_e;

  function automatic logic [3:0] icode_of(input logic [31:0] word);
    return word[31:28];
  endfunction

endpackage

// File: rtl/imem_arb.sv
// Two-requester RAM arbiter: fetch wins while fetch_en is high, but a host
// that has been denied STARVE_MAX cycles in a row is forced through once.
module imem_arb
  import procz_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic fetch_en,
  input  logic host_req,
  input  logic fetch_req,
  output logic host_gnt,
  output logic fetch_gnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_host;

  assign force_host = fetch_en && (starve_cnt >= CNT_W'(STARVE_MAX));

  always_comb begin
    host_gnt  = host_req;
    fetch_gnt = 1'b0;
    if (fetch_en) begin
      fetch_gnt = fetch_req & ~force_host;
      host_gnt  = host_req & (~fetch_req | force_host);
    end
  end

  // Counts consecutive denied host cycles; any grant or idle host restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_gnt || !host_req) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_run_ctrl.sv
// Run/halt controller and instruction RAM arbiter for processor Z.
// Optional IMEM_RUN_CYCLE_COUNT_EN adds a saturating run_cycles counter.
module imem_run_ctrl
  import procz_pkg::*;
#(
  parameter int         ADDR_W     = PROCZ_ADDR_W,
  parameter int         DATA_W     = PROCZ_DATA_W,
  parameter logic [3:0] HALT_ICODE = ICODE_HALT,
  parameter int         DRAIN_CYC  = 3,
  parameter int         STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              working,
  output logic [1:0]        run_state,
`ifdef IMEM_RUN_CYCLE_COUNT_EN
  output logic              halted,
  output logic [31:0]       run_cycles
`else
  output logic              halted
`endif
);

  localparam int DRAIN_W = $clog2(DRAIN_CYC + 2);

  run_state_e         state;
  run_state_e         next_state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               host_rd_pend;
  logic               fetch_rd_pend;
  logic               fetch_en;
  logic               halt_seen;

  assign fetch_en  = (state == RUN);
  // Only RUN inspects returned words, so a fetch landing during DRAIN is ignored.
  assign halt_seen = fetch_rvalid && (icode_of(fetch_rdata[31:0]) == HALT_ICODE);

  imem_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .fetch_en (fetch_en),
    .host_req (host_req),
    .fetch_req(fetch_req),
    .host_gnt (host_gnt),
    .fetch_gnt(fetch_gnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    working    = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) next_state = RUN;
      end
      RUN: begin
        working = 1'b1;
        if (stop || halt_seen) next_state = DRAIN;
      end
      DRAIN: begin
        working = 1'b1;
        if (drain_cnt == '0) next_state = HALT;
      end
      HALT: begin
        halted = 1'b1;
        if (start) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  assign run_state = state;

  // Keeps the pipeline enabled long enough for D/E/W to retire after a stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == RUN && next_state == DRAIN) begin
      drain_cnt <= DRAIN_W'(DRAIN_CYC);
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_wdata = '0;
    ram_rd    = 1'b0;
    if (fetch_gnt) begin
      ram_addr = fetch_addr;
      ram_rd   = 1'b1;
    end else if (host_gnt) begin
      ram_addr  = host_addr;
      ram_wr    = host_wr;
      ram_wdata = host_wdata;
      ram_rd    = ~host_wr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      host_rd_pend  <= 1'b0;
      fetch_rd_pend <= 1'b0;
    end else begin
      host_rd_pend  <= host_gnt & ~host_wr & ~fetch_gnt;
      fetch_rd_pend <= fetch_gnt;
    end
  end

  assign host_rvalid  = host_rd_pend;
  assign fetch_rvalid = fetch_rd_pend;
  assign host_rdata   = ram_rdata;
  assign fetch_rdata  = ram_rdata;

`ifdef IMEM_RUN_CYCLE_COUNT_EN
  // Restarts only on a fresh launch from IDLE; a resume from HALT keeps counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cycles <= '0;
    end else if (state == IDLE && next_state == RUN) begin
      run_cycles <= '0;
    end else if (working && run_cycles != 32'hFFFF_FFFF) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_run_ctrl.sv
// Self-checking bench for imem_run_ctrl: directed table, random traffic
// against a behavioural model, and a reset-during-DRAIN sequence.
module tb_imem_run_ctrl;

  localparam int STARVE = 8;
  localparam int DRAINC = 3;

  typedef struct {
    bit          start;
    bit          stop;
    bit          hreq;
    bit          hwr;
    logic [8:0]  haddr;
    logic [31:0] hwdata;
    bit          freq;
    logic [8:0]  faddr;
    bit          e_hg;
    bit          e_fg;
    bit          e_hv;
    bit          e_fv;
    bit          e_work;
    logic [1:0]  e_st;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        host_req, host_wr, host_gnt, host_rvalid;
  logic [8:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        fetch_req, fetch_gnt, fetch_rvalid;
  logic [8:0]  fetch_addr;
  logic [31:0] fetch_rdata;
  logic        start, stop;
  logic [8:0]  ram_addr;
  logic        ram_wr, ram_rd;
  logic [31:0] ram_wdata, ram_rdata;
  logic        working, halted;
  logic [1:0]  run_state;
`ifdef IMEM_RUN_CYCLE_COUNT_EN
  logic [31:0] run_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem [0:511];

  int          m_state, m_starve, m_drain;
  bit          m_hpend, m_fpend;
  logic [31:0] m_word;
  logic [31:0] m_mem [0:511];
  logic [31:0] m_cycles;
  bit          e_hg, e_fg;

  always #5 clock = ~clock;

  imem_run_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .host_req    (host_req),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata (fetch_rdata),
    .start       (start),
    .stop        (stop),
    .ram_addr    (ram_addr),
    .ram_wr      (ram_wr),
    .ram_wdata   (ram_wdata),
    .ram_rd      (ram_rd),
    .ram_rdata   (ram_rdata),
    .working     (working),
    .run_state   (run_state),
`ifdef IMEM_RUN_CYCLE_COUNT_EN
    .halted      (halted),
    .run_cycles  (run_cycles)
`else
    .halted      (halted)
`endif
  );

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_starve = 0;
    m_drain  = 0;
    m_hpend  = 1'b0;
    m_fpend  = 1'b0;
    m_cycles = '0;
  endtask

  task automatic modelComb();
    bit force_host;
    force_host = (m_state == 1) && (m_starve >= STARVE);
    e_fg = (m_state == 1) && fetch_req && !force_host;
    e_hg = host_req && ((m_state != 1) || !fetch_req || force_host);
  endtask

  task automatic modelEdge();
    int nxt;
    nxt = m_state;
    case (m_state)
      0: if (start && !stop) nxt = 1;
      1: if (stop || (m_fpend && m_word[31:28] == 4'h0)) nxt = 2;
      2: if (m_drain == 0) nxt = 3;
      default: if (start) nxt = 1;
    endcase
    if (m_state == 0 && nxt == 1) m_cycles = '0;
    else if ((m_state == 1 || m_state == 2) && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    if (m_state == 1 && nxt == 2) m_drain = DRAINC;
    else if (m_state == 2 && m_drain > 0) m_drain = m_drain - 1;
    if (e_hg || !host_req) m_starve = 0;
    else m_starve = m_starve + 1;
    m_hpend = e_hg && !host_wr;
    m_fpend = e_fg;
    if (e_fg) m_word = m_mem[fetch_addr];
    else if (e_hg && !host_wr) m_word = m_mem[host_addr];
    if (e_hg && host_wr) m_mem[host_addr] = host_wdata;
    m_state = nxt;
  endtask

  task automatic checkModel();
    checkOutput("host_gnt", 32'(host_gnt), 32'(e_hg));
    checkOutput("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(m_hpend));
    checkOutput("fetch_rvalid", 32'(fetch_rvalid), 32'(m_fpend));
    checkOutput("working", 32'(working), 32'(m_state == 1 || m_state == 2));
    checkOutput("halted", 32'(halted), 32'(m_state == 3));
    checkOutput("run_state", 32'(run_state), 32'(m_state));
    checkOutput("ram_rd", 32'(ram_rd), 32'(e_fg || (e_hg && !host_wr)));
    checkOutput("ram_wr", 32'(ram_wr), 32'(!e_fg && e_hg && host_wr));
    if (e_fg) checkOutput("ram_addr_fetch", 32'(ram_addr), 32'(fetch_addr));
    else if (e_hg) checkOutput("ram_addr_host", 32'(ram_addr), 32'(host_addr));
    if (e_hg && host_wr) checkOutput("ram_wdata", ram_wdata, host_wdata);
    if (m_hpend) checkOutput("host_rdata", host_rdata, m_word);
    if (m_fpend) checkOutput("fetch_rdata", fetch_rdata, m_word);
`ifdef IMEM_RUN_CYCLE_COUNT_EN
    checkOutput("run_cycles", run_cycles, m_cycles);
`endif
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_tab, input int idx);
    start      = v.start;
    stop       = v.stop;
    host_req   = v.hreq;
    host_wr    = v.hwr;
    host_addr  = v.haddr;
    host_wdata = v.hwdata;
    fetch_req  = v.freq;
    fetch_addr = v.faddr;
    modelComb();
    @(negedge clock);
    checkModel();
    if (use_tab) begin
      checkOutput($sformatf("tab%0d_host_gnt", idx), 32'(host_gnt), 32'(v.e_hg));
      checkOutput($sformatf("tab%0d_fetch_gnt", idx), 32'(fetch_gnt), 32'(v.e_fg));
      checkOutput($sformatf("tab%0d_host_rvalid", idx), 32'(host_rvalid), 32'(v.e_hv));
      checkOutput($sformatf("tab%0d_fetch_rvalid", idx), 32'(fetch_rvalid), 32'(v.e_fv));
      checkOutput($sformatf("tab%0d_working", idx), 32'(working), 32'(v.e_work));
      checkOutput($sformatf("tab%0d_run_state", idx), 32'(run_state), 32'(v.e_st));
    end
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  function automatic vec_t mk(bit st, bit sp, bit hr, bit hw, int ha, logic [31:0] hd,
                              bit fr, int fa, bit ehg, bit efg, bit ehv, bit efv,
                              bit ew, int est);
    vec_t v;
    v.start = st;  v.stop = sp;  v.hreq = hr;  v.hwr = hw;
    v.haddr = 9'(ha);  v.hwdata = hd;  v.freq = fr;  v.faddr = 9'(fa);
    v.e_hg = ehg;  v.e_fg = efg;  v.e_hv = ehv;  v.e_fv = efv;
    v.e_work = ew;  v.e_st = 2'(est);
    return v;
  endfunction

  vec_t tab[$];
  vec_t rv;
  vec_t idle_v;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    m_word = '0;
    idle_v = mk(0,0,0,0,0,0, 0,0, 0,0,0,0,0,0);

    // Load, start+stop in IDLE, run with starvation, halt word, HALT events, stop timing
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0,1,1,0,32'h10F00080, 0,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,1,0,0,32'h0,        0,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,1,0,0,0));
    tab.push_back(mk(0,0,1,1,1,32'h10F00081, 0,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,1,1,2,32'h20000000, 0,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,1,1,3,32'h30000000, 0,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,1,1,4,32'h00000000, 0,0, 1,0,0,0,0,0));
    tab.push_back(mk(1,1,0,0,0,32'h0,        0,0, 0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0));
    tab.push_back(mk(1,0,1,0,5,32'h0,        1,0, 1,0,0,0,0,0));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,0, 0,1,1,0,1,1));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,1, 0,1,0,1,1,1));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,2, 0,1,0,1,1,1));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,3, 0,1,0,1,1,1));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0,0,1,0,5,32'h0,      1,0, 0,1,0,1,1,1));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,0, 1,0,0,1,1,1));
    tab.push_back(mk(0,0,1,0,5,32'h0,        1,0, 0,1,1,0,1,1));
    tab.push_back(mk(0,0,0,0,0,32'h0,        1,4, 0,1,0,1,1,1));
    tab.push_back(mk(0,0,0,0,0,32'h0,        1,0, 0,1,0,1,1,1));
    tab.push_back(mk(0,0,0,0,0,32'h0,        1,0, 0,0,0,1,1,2));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0,0,0,0,0,32'h0,      1,0, 0,0,0,0,1,2));
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,0,0,0,3));
    tab.push_back(mk(0,1,0,0,0,32'h0,        0,0, 0,0,0,0,0,3));
    tab.push_back(mk(1,1,0,0,0,32'h0,        0,0, 0,0,0,0,0,3));
    tab.push_back(mk(0,1,0,0,0,32'h0,        1,0, 0,1,0,0,1,1));
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,0,1,1,2));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(0,0,0,0,0,32'h0,      0,0, 0,0,0,0,1,2));
    tab.push_back(mk(0,0,0,0,0,32'h0,        0,0, 0,0,0,0,0,3));

    reset = 1'b1;
    start = 0; stop = 0; host_req = 0; host_wr = 0; host_addr = '0;
    host_wdata = '0; fetch_req = 0; fetch_addr = '0;
    modelReset();
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("rst_working", 32'(working), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_run_state", 32'(run_state), 32'd0);
    checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    checkOutput("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
`ifdef IMEM_RUN_CYCLE_COUNT_EN
    checkOutput("rst_run_cycles", run_cycles, 32'd0);
`endif
    reset = 1'b0;

    foreach (tab[i]) applyStimulus(tab[i], 1'b1, i);

    for (int n = 0; n < 400; n++) begin
      rv = idle_v;
      rv.start  = ($urandom_range(7) == 0);
      rv.stop   = ($urandom_range(15) == 0);
      rv.hreq   = ($urandom_range(2) != 0);
      rv.hwr    = ($urandom_range(2) == 0);
      rv.haddr  = 9'($urandom_range(15));
      rv.hwdata = $urandom;
      rv.freq   = ($urandom_range(3) != 0);
      rv.faddr  = 9'($urandom_range(15));
      applyStimulus(rv, 1'b0, n);
    end

    // Reset asserted in DRAIN while a host read is outstanding
    reset = 1'b1;
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rv = idle_v;  rv.start = 1;
    applyStimulus(rv, 1'b0, 0);
    rv = idle_v;  rv.stop = 1;  rv.freq = 1;
    applyStimulus(rv, 1'b0, 1);
    rv = idle_v;  rv.hreq = 1;  rv.haddr = 9'd1;
    applyStimulus(rv, 1'b0, 2);
    checkOutput("pre_rst_state", 32'(run_state), 32'd2);
    host_req = 0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_working", 32'(working), 32'd0);
    checkOutput("midrst_run_state", 32'(run_state), 32'd0);
    checkOutput("midrst_halted", 32'(halted), 32'd0);
    checkOutput("midrst_host_rvalid", 32'(host_rvalid), 32'd0);
    checkOutput("midrst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    checkOutput("midrst_host_gnt", 32'(host_gnt), 32'd0);
`ifdef IMEM_RUN_CYCLE_COUNT_EN
    checkOutput("midrst_run_cycles", run_cycles, 32'd0);
`endif
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(idle_v, 1'b0, 3);
    applyStimulus(idle_v, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_run_ctrl.md
# imem_run_ctrl

Run controller and arbiter for the single-port instruction RAM of processor Z. Owns the run/halt state machine, generates `working` for the pipeline, and shares the 512×32 RAM between the host loader port and the fetch stage. Sits between the testbench/host, the fetch stage and `ram`. Replaces the ad-hoc `working ? PC : addr` mux in the processor top.

## Interface
Parameters:
- ADDR_W, 9, RAM address width
- DATA_W, 32, RAM word width
- HALT_ICODE, 4'h0, icode in bits [31:28] that stops execution
- DRAIN_CYC, 3, cycles to hold `working` after a stop so D/E/W stages retire
- STARVE_MAX, 8, consecutive denied host cycles in RUN before a forced host grant

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- host_req  in  1  host access request
- host_wr  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- fetch_req  in  1  fetch stage read request
- fetch_addr  in  ADDR_W  PC
- fetch_gnt  out  1  fetch accepted this cycle
- fetch_rvalid  out  1  instruction word valid
- fetch_rdata  out  DATA_W  instruction word
- start  in  1  begin/resume execution
- stop  in  1  request halt
- ram_addr / ram_wr / ram_wdata / ram_rd  out  ADDR_W/1/DATA_W/1  to `ram`
- ram_rdata  in  DATA_W  from `ram`
- working  out  1  pipeline enable
- run_state  out  2  current FSM state
- halted  out  1  high in HALT

## Operation
- States: IDLE=0, RUN=1, DRAIN=2, HALT=3.
- IDLE: host sole owner; `host_gnt = host_req`, `fetch_gnt = 0`. `start` -> RUN. `start` and `stop` together -> stay IDLE.
- RUN: `working = 1`. Fetch has priority: `fetch_gnt = fetch_req`, and `host_gnt = host_req & ~fetch_req`.
  - Starvation counter increments each cycle `host_req` is denied. When it reaches STARVE_MAX, the next cycle grants the host and denies fetch. Counter clears on any host grant or when `host_req` is low.
  - `stop`, or `fetch_rvalid` with `fetch_rdata[31:28] == HALT_ICODE` -> DRAIN.
- DRAIN: `working = 1`, `fetch_gnt = 0`, host arbitrated as in IDLE. Drain counter loads DRAIN_CYC on entry and decrements each cycle. At 0 -> HALT. A fetch read in flight on entry still returns its `fetch_rvalid`, and that word is ignored for halt detection.
- HALT: `working = 0`, `halted = 1`, host sole owner. `start` -> RUN; `stop` is ignored.
- RAM mux: the granted requester drives `ram_addr`/`ram_wr`/`ram_wdata`. `ram_rd` = granted read. No grant -> `ram_rd = 0`, `ram_wr = 0`.
- Reads: RAM data is returned on the cycle after the grant. The controller registers which requester owns the read and raises that requester's `rvalid` for one cycle. Both `rdata` outputs pass `ram_rdata` through.
- Host writes never produce `rvalid`.

## Timing
- Grants and RAM-side outputs are combinational from requests and state, with no added latency.
- `rvalid` rises exactly 1 cycle after a read grant. Throughput is 1 access per cycle.
- `working` rises in the cycle after `start` is sampled in IDLE/HALT. It falls DRAIN_CYC+1 cycles after `stop` is sampled in RUN.
- Reset values: state IDLE, `working = 0`, `halted = 0`, all `gnt`/`rvalid` 0, counters 0, `run_state = 0`.
- Reset mid-read drops the pending `rvalid`.

## Configuration
- `IMEM_RUN_CYCLE_COUNT_EN` defined:
  - adds output `run_cycles` [31:0], which counts cycles with `working = 1`;
  - the count saturates at 32'hFFFF_FFFF;
  - it clears on reset and on the `start` that leaves IDLE, and holds through HALT and resume.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `procz_pkg`: state enum (IDLE/RUN/DRAIN/HALT), `ICODE_HALT`, and ADDR_W/DATA_W constants shared with `ram`/`regfile`.
- One sub-module, `imem_arb`: a two-requester priority arbiter with starvation counter, instantiated by the FSM top.

## Test plan
- Load: in IDLE, host writes 32'h10F00080 to addr 0 and reads it back -> `host_gnt` each cycle, `host_rvalid` one cycle later, `host_rdata = 32'h10F00080`.
- Run: `start` with `fetch_req` held and PC 0..3 -> `working` rises the next cycle, `fetch_rvalid` follows each grant by 1 cycle, and the host is denied throughout.
- Starvation: in RUN, `fetch_req` and `host_req` held continuously -> host granted on the 9th cycle, fetch denied that cycle only.
- Halt instruction: word 32'h00000000 at addr 4 -> DRAIN after its `rvalid`, `working` low 4 cycles later, `halted = 1`.
- Simultaneous events: `start` + `stop` in IDLE -> stays IDLE. `stop` in HALT -> no change. `start` in HALT -> RUN.
- Reset: assert reset mid-DRAIN with a read pending -> outputs at reset values immediately, no `rvalid`; with `IMEM_RUN_CYCLE_COUNT_EN`, `run_cycles = 0`.
